// File: rtl/ir_move_receiver_if.sv
// Command bus from the IR move receiver to the rover motor sequencer.
// master = receiver side (drives), slave = consumer side.
interface ir_move_receiver_if;
    logic [11:0] move_command;
    logic        command_valid;
    logic        frame_error;
    logic        busy;

    modport master (
        output move_command,
        output command_valid,
        output frame_error,
        output busy
    );

    modport slave (
        input move_command,
        input command_valid,
        input frame_error,
        input busy
    );
endinterface

// File: rtl/ir_move_receiver.sv
// Pulse-width IR move-command receiver with repeat-burst suppression.
// Optional IR_CONFIRM_EN: a command is only a candidate after two identical copies.
module ir_move_receiver #(
    parameter int unsigned CLK_PER_UNIT   = 16200,
    parameter int unsigned HOLDOFF_CYCLES = 8100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ir_in,
    ir_move_receiver_if.master bus
);
    localparam logic [19:0] LEN_0P5 = 20'(CLK_PER_UNIT / 2);
    localparam logic [19:0] LEN_1P5 = 20'((3 * CLK_PER_UNIT) / 2);
    localparam logic [19:0] LEN_2P5 = 20'((5 * CLK_PER_UNIT) / 2);
    localparam logic [19:0] LEN_3P5 = 20'((7 * CLK_PER_UNIT) / 2);
    localparam logic [19:0] LEN_5   = 20'(5 * CLK_PER_UNIT);
    localparam logic [19:0] LEN_SAT = 20'(6 * CLK_PER_UNIT);
    localparam logic [23:0] HOLD_LOAD = 24'(HOLDOFF_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        START_MARK,
        SPACE,
        DATA_MARK,
        CHECK
    } state_t;

    logic        ir_s1, ir_s2, ir_d;
    logic        rise, fall;
    logic [19:0] len;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [11:0] shreg, shreg_n;
    logic [11:0] cmd_q, cmd_n;
    logic        valid_q, valid_n;
    logic        err_q, err_n;
    logic [23:0] holdoff, holdoff_n;
    logic        candidate;

`ifdef IR_CONFIRM_EN
    logic [11:0] pend, pend_n;
    logic        pend_vld, pend_vld_n;
    logic [23:0] pend_tmr, pend_tmr_n;
`endif

    logic is_start, is_one, is_zero, space_ok;

    // Synchronizer, edge detect and saturating segment-length counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_s1 <= 1'b0;
            ir_s2 <= 1'b0;
            ir_d  <= 1'b0;
            len   <= '0;
        end else begin
            ir_s1 <= ir_in;
            ir_s2 <= ir_s1;
            ir_d  <= ir_s2;
            if (rise || fall)
                len <= '0;
            else if (len != LEN_SAT)
                len <= len + 20'd1;
        end
    end

    assign rise = ir_s2 & ~ir_d;
    assign fall = ~ir_s2 & ir_d;

    assign is_start = (len >= LEN_3P5) && (len < LEN_5);
    assign is_one   = (len >= LEN_1P5) && (len < LEN_2P5);
    assign is_zero  = (len >= LEN_0P5) && (len < LEN_1P5);
    assign space_ok = (len >= LEN_0P5) && (len < LEN_1P5);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            cmd_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            holdoff  <= '0;
`ifdef IR_CONFIRM_EN
            pend     <= '0;
            pend_vld <= 1'b0;
            pend_tmr <= '0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            cmd_q    <= cmd_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
            holdoff  <= holdoff_n;
`ifdef IR_CONFIRM_EN
            pend     <= pend_n;
            pend_vld <= pend_vld_n;
            pend_tmr <= pend_tmr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        cmd_n     = cmd_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        candidate = 1'b1;
        holdoff_n = (holdoff != '0) ? holdoff - 24'd1 : '0;
`ifdef IR_CONFIRM_EN
        pend_n     = pend;
        pend_vld_n = pend_vld;
        pend_tmr_n = (pend_tmr != '0) ? pend_tmr - 24'd1 : '0;
`endif

        case (state)
            IDLE: begin
                if (rise)
                    state_n = START_MARK;
            end
            START_MARK: begin
                if (fall) begin
                    if (is_start) begin
                        state_n   = SPACE;
                        bit_cnt_n = '0;
                        shreg_n   = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SPACE: begin
                if (rise) begin
                    if (space_ok)
                        state_n = DATA_MARK;
                    else
                        err_n = 1'b1;
                end else if (len >= LEN_1P5) begin
                    err_n = 1'b1;
                end
            end
            DATA_MARK: begin
                if (fall) begin
                    if (is_one || is_zero) begin
                        shreg_n[bit_cnt] = is_one;
                        bit_cnt_n        = bit_cnt + 4'd1;
                        state_n          = (bit_cnt == 4'd11) ? CHECK : SPACE;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (len == LEN_SAT) begin
                    err_n = 1'b1;
                end
            end
            CHECK: begin
                state_n   = IDLE;
                holdoff_n = holdoff;
`ifdef IR_CONFIRM_EN
                // Only the second matching copy inside the window is a candidate.
                candidate  = pend_vld && (pend == shreg) && (pend_tmr != '0);
                pend_n     = shreg;
                pend_vld_n = 1'b1;
                pend_tmr_n = HOLD_LOAD;
`endif
                if (candidate) begin
                    holdoff_n = HOLD_LOAD;
                    if (!((shreg == cmd_q) && (holdoff != '0))) begin
                        cmd_n   = shreg;
                        valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (err_n) begin
            state_n = IDLE;
`ifdef IR_CONFIRM_EN
            pend_vld_n = 1'b0;
`endif
        end
    end

    assign bus.move_command  = cmd_q;
    assign bus.command_valid = valid_q;
    assign bus.frame_error   = err_q;
    assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_ir_move_receiver.sv
// Self-checking bench for ir_move_receiver against a time-based model of the accept rules.
module tb_ir_move_receiver;
    localparam int U    = 10;
    localparam int HOLD = 2000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ir_in = 1'b0;

    ir_move_receiver_if ifc ();

    ir_move_receiver #(
        .CLK_PER_UNIT  (U),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ir_in(ir_in),
        .bus  (ifc)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int     vcnt = 0;
    int     ecnt = 0;
    int     both_cnt = 0;
    longint last_vcyc = 0;
    longint fall_cyc = 0;

    always @(negedge clock) begin
        if (ifc.command_valid) begin
            vcnt++;
            last_vcyc = cyc;
        end
        if (ifc.frame_error) ecnt++;
        if (ifc.command_valid && ifc.frame_error) both_cnt++;
    end

    // Reference model: accept rules expressed over absolute frame-end times.
    logic [11:0] m_cmd;
    bit          m_hold_vld;
    longint      m_hold_t;
`ifdef IR_CONFIRM_EN
    logic [11:0] m_pend;
    bit          m_pend_vld;
    longint      m_pend_t;
`endif

    task automatic model_reset();
        m_cmd = '0;
        m_hold_vld = 0;
        m_hold_t = 0;
`ifdef IR_CONFIRM_EN
        m_pend = '0;
        m_pend_vld = 0;
        m_pend_t = 0;
`endif
    endtask

    task automatic model_error();
`ifdef IR_CONFIRM_EN
        m_pend_vld = 0;
`endif
    endtask

    task automatic model_frame(input logic [11:0] cmd, input longint t, output int exp_v);
        bit hold_active;
        bit cand;
        hold_active = m_hold_vld && ((t - m_hold_t) <= HOLD);
        cand = 1;
`ifdef IR_CONFIRM_EN
        cand = m_pend_vld && (m_pend == cmd) && ((t - m_pend_t) <= HOLD);
        m_pend = cmd;
        m_pend_vld = 1;
        m_pend_t = t;
`endif
        exp_v = 0;
        if (cand) begin
            if (!(cmd == m_cmd && hold_active)) begin
                m_cmd = cmd;
                exp_v = 1;
            end
            m_hold_vld = 1;
            m_hold_t = t;
        end
    endtask

    task automatic drive(input logic v, input int cycles);
        ir_in = v;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // fault: 0 clean, 1 start 7u, 2 bit-5 mark 3u, 3 space 2u before bit 3, 4 stop inside bit-6 mark
    task automatic send_frame(input logic [11:0] cmd, input int fault, input int gap_u);
        drive(1'b1, (fault == 1 ? 7 : 4) * U);
        if (fault == 1) begin
            drive(1'b0, gap_u * U);
            return;
        end
        for (int b = 0; b < 12; b++) begin
            if (fault == 3 && b == 3) begin
                drive(1'b0, (2 + gap_u) * U);
                return;
            end
            drive(1'b0, U);
            if (fault == 4 && b == 6) begin
                drive(1'b1, U / 2);
                return;
            end
            if (fault == 2 && b == 5) begin
                drive(1'b1, 3 * U);
                drive(1'b0, gap_u * U);
                return;
            end
            drive(1'b1, cmd[b] ? 2 * U : U);
        end
        ir_in = 1'b0;
        fall_cyc = cyc;
        drive(1'b0, gap_u * U);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        tests++; if (ifc.move_command !== 12'h000) begin fails++; $display("FAIL reset_cmd got %h want 000", ifc.move_command); end
        tests++; if (ifc.command_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ifc.command_valid); end
        tests++; if (ifc.frame_error !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", ifc.frame_error); end
        tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        reset = 1'b0;
        model_reset();
        drive(1'b0, 5);
    endtask

    task automatic test_single();
        int v0, e0, exp_v;
        v0 = vcnt; e0 = ecnt;
        send_frame(12'h00A, 0, 40);
        model_frame(12'h00A, fall_cyc, exp_v);
        tests++; if (vcnt - v0 !== exp_v) begin fails++; $display("FAIL single_pulses got %0d want %0d", vcnt - v0, exp_v); end
        tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL single_cmd got %h want %h", ifc.move_command, m_cmd); end
        tests++; if (ecnt - e0 !== 0) begin fails++; $display("FAIL single_err got %0d want 0", ecnt - e0); end
        if (exp_v == 1) begin
            tests++; if (last_vcyc - fall_cyc !== 4) begin fails++; $display("FAIL single_latency got %0d want 4", last_vcyc - fall_cyc); end
        end
    endtask

    task automatic test_repeat();
        int v0, exp_v, exp_sum;
        drive(1'b0, 250 * U);
        v0 = vcnt; exp_sum = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(12'h3C5, 0, 40);
            model_frame(12'h3C5, fall_cyc, exp_v);
            exp_sum += exp_v;
        end
        tests++; if (vcnt - v0 !== exp_sum) begin fails++; $display("FAIL repeat_pulses got %0d want %0d", vcnt - v0, exp_sum); end
        tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL repeat_cmd got %h want %h", ifc.move_command, m_cmd); end
    endtask

    task automatic test_change();
        int v0, exp_v, exp_sum;
        drive(1'b0, 250 * U);
        v0 = vcnt; exp_sum = 0;
        send_frame(12'h3C5, 0, 40);
        model_frame(12'h3C5, fall_cyc, exp_v);
        exp_sum += exp_v;
        send_frame(12'h105, 0, 40);
        model_frame(12'h105, fall_cyc, exp_v);
        exp_sum += exp_v;
        tests++; if (vcnt - v0 !== exp_sum) begin fails++; $display("FAIL change_pulses got %0d want %0d", vcnt - v0, exp_sum); end
        tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL change_cmd got %h want %h", ifc.move_command, m_cmd); end
    endtask

    task automatic test_errors();
        int v0, e0;
        for (int f = 1; f <= 3; f++) begin
            drive(1'b0, 20 * U);
            v0 = vcnt; e0 = ecnt;
            send_frame(12'h5A5, f, 40);
            model_error();
            tests++; if (ecnt - e0 !== 1) begin fails++; $display("FAIL err%0d_count got %0d want 1", f, ecnt - e0); end
            tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL err%0d_valid got %0d want 0", f, vcnt - v0); end
            tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL err%0d_cmd got %h want %h", f, ifc.move_command, m_cmd); end
        end
    endtask

    task automatic test_midreset();
        int v0, e0, exp_v, exp_sum;
        drive(1'b0, 20 * U);
        v0 = vcnt; e0 = ecnt;
        send_frame(12'h0FF, 4, 0);
        reset = 1'b1;
        ir_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (ifc.move_command !== 12'h000) begin fails++; $display("FAIL midrst_cmd got %h want 000", ifc.move_command); end
        tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", ifc.busy); end
        reset = 1'b0;
        model_reset();
        drive(1'b0, 20);
        tests++; if ((vcnt - v0) + (ecnt - e0) !== 0) begin fails++; $display("FAIL midrst_pulses got %0d want 0", (vcnt - v0) + (ecnt - e0)); end
        v0 = vcnt; exp_sum = 0;
`ifdef IR_CONFIRM_EN
        send_frame(12'h0FF, 0, 40);
        model_frame(12'h0FF, fall_cyc, exp_v);
        exp_sum += exp_v;
`endif
        send_frame(12'h0FF, 0, 40);
        model_frame(12'h0FF, fall_cyc, exp_v);
        exp_sum += exp_v;
        tests++; if (vcnt - v0 !== exp_sum) begin fails++; $display("FAIL midrst_accept got %0d want %0d", vcnt - v0, exp_sum); end
        tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL midrst_cmd2 got %h want %h", ifc.move_command, m_cmd); end
    endtask

    task automatic test_confirm();
        int v0, e0, exp_v, exp_sum;
        drive(1'b0, 250 * U);
        v0 = vcnt; exp_sum = 0;
        send_frame(12'h00A, 0, 40);
        model_frame(12'h00A, fall_cyc, exp_v);
        exp_sum += exp_v;
        send_frame(12'h00A, 0, 40);
        model_frame(12'h00A, fall_cyc, exp_v);
        exp_sum += exp_v;
        tests++; if (vcnt - v0 !== exp_sum) begin fails++; $display("FAIL confirm_pair got %0d want %0d", vcnt - v0, exp_sum); end
        drive(1'b0, 250 * U);
        v0 = vcnt; e0 = ecnt; exp_sum = 0;
        send_frame(12'h00A, 0, 40);
        model_frame(12'h00A, fall_cyc, exp_v);
        exp_sum += exp_v;
        send_frame(12'h00A, 2, 40);
        model_error();
        send_frame(12'h00A, 0, 40);
        model_frame(12'h00A, fall_cyc, exp_v);
        exp_sum += exp_v;
        tests++; if (vcnt - v0 !== exp_sum) begin fails++; $display("FAIL confirm_err_pulses got %0d want %0d", vcnt - v0, exp_sum); end
        tests++; if (ecnt - e0 !== 1) begin fails++; $display("FAIL confirm_err_count got %0d want 1", ecnt - e0); end
        tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL confirm_cmd got %h want %h", ifc.move_command, m_cmd); end
    endtask

    task automatic test_random();
        int v0, e0, exp_v, gap;
        logic [11:0] cmd, last;
        last = m_cmd;
        for (int i = 0; i < 12; i++) begin
            cmd = ($urandom_range(0, 2) == 0) ? last : 12'($urandom());
            gap = ($urandom_range(0, 1) == 0) ? 40 : 250;
            v0 = vcnt; e0 = ecnt;
            send_frame(cmd, 0, gap);
            model_frame(cmd, fall_cyc, exp_v);
            last = cmd;
            tests++; if (vcnt - v0 !== exp_v || ecnt - e0 !== 0) begin fails++; $display("FAIL rand%0d_pulses cmd %h got v=%0d e=%0d want v=%0d e=0", i, cmd, vcnt - v0, ecnt - e0, exp_v); end
            tests++; if (ifc.move_command !== m_cmd) begin fails++; $display("FAIL rand%0d_cmd got %h want %h", i, ifc.move_command, m_cmd); end
        end
    endtask

    task automatic test_exclusive();
        tests++; if (both_cnt !== 0) begin fails++; $display("FAIL exclusive got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_single();
        test_repeat();
        test_change();
        test_errors();
        test_midreset();
        test_confirm();
        test_random();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
